// File: rtl/apb_req_master_if.sv
// Request/grant/response and APB bus signals of apb_req_master.
// The master modport is the initiator's own view; slave is the view of the requester plus APB slave.
interface apb_req_master_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
) ();
  logic                      req_i;
  logic                      we_i;
  logic [APB_ADDR_WIDTH-1:0] addr_i;
  logic [APB_DATA_WIDTH-1:0] wdata_i;
  logic                      gnt_o;
  logic                      rvalid_o;
  logic [APB_DATA_WIDTH-1:0] rdata_o;
  logic                      err_o;
  logic [APB_ADDR_WIDTH-1:0] paddr_o;
  logic [APB_DATA_WIDTH-1:0] pwdata_o;
  logic                      pwrite_o;
  logic                      psel_o;
  logic                      penable_o;
  logic [APB_DATA_WIDTH-1:0] prdata_i;
  logic                      pready_i;
  logic                      pslverr_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );
endinterface

// File: rtl/apb_req_master.sv
// Single-channel APB initiator: serialises core requests into APB SETUP/ACCESS transfers.
// Define APB_MASTER_TIMEOUT_EN to abort transfers whose slave never asserts pready.
module apb_req_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              clk_i,
  input logic              rst_ni,
  apb_req_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          paddr_d  = bus.addr_i;
          pwdata_d = bus.wdata_i;
          pwrite_d = bus.we_i;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StAccess: begin
        if (bus.pready_i) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          err_d    = bus.pslverr_i;
          rdata_d  = pwrite_q ? '0 : bus.prdata_i;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CntW'(1);
          // Limit cycle without pready: abort with an error response.
          if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = StIdle;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.gnt_o     = bus.req_i & (state_q == StIdle);
  assign bus.psel_o    = (state_q != StIdle);
  assign bus.penable_o = (state_q == StAccess);
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.err_o     = err_q;
  assign bus.rdata_o   = rdata_q;

endmodule

// File: doc/apb_req_master.md
# apb_req_master

Single-channel APB initiator that turns a core-side request/grant/response interface into APB SETUP/ACCESS transactions. It sits upstream of the APB node/decoder and drives its slave port. It serialises one transfer at a time and returns read data plus slave error to the requester. An optional watchdog aborts transfers whose slave never asserts `pready`.

## Interface
- `APB_ADDR_WIDTH`, 32, APB address width.
- `APB_DATA_WIDTH`, 32, APB data width.
- `TIMEOUT_CYCLES`, 256, ACCESS-phase cycle limit. Must be ≥1. Used only with the watchdog macro.

- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_i`  in  1  request valid.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  APB_ADDR_WIDTH  request address.
- `wdata_i`  in  APB_DATA_WIDTH  write data.
- `gnt_o`  out  1  request accepted (combinational).
- `rvalid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  APB_DATA_WIDTH  read data; valid with `rvalid_o`.
- `err_o`  out  1  transfer error; valid with `rvalid_o`.
- `paddr_o`  out  APB_ADDR_WIDTH  APB address.
- `pwdata_o`  out  APB_DATA_WIDTH  APB write data.
- `pwrite_o`  out  1  APB direction.
- `psel_o`  out  1  APB select.
- `penable_o`  out  1  APB enable.
- `prdata_i`  in  APB_DATA_WIDTH  APB read data.
- `pready_i`  in  1  APB ready.
- `pslverr_i`  in  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- `gnt_o = req_i & (state == IDLE)`.
- On grant:
  - register `addr_i`, `wdata_i`, `we_i` into `paddr_o`, `pwdata_o`, `pwrite_o`;
  - go to SETUP.
- SETUP: `psel_o = 1`, `penable_o = 0`. Unconditionally go to ACCESS.
- ACCESS: `psel_o = 1`, `penable_o = 1`.
  - `pready_i = 0`: stay in ACCESS.
  - `pready_i = 1`: go to IDLE; next cycle `rvalid_o = 1` and `err_o = pslverr_i`.
  - `rdata_o = prdata_i` for reads, `0` for writes.
- `paddr_o`, `pwdata_o`, `pwrite_o` stay stable from SETUP through the last ACCESS cycle. In IDLE they hold their last values.
- `rdata_o` and `err_o` hold their last values after `rvalid_o` drops.
- Outputs `psel_o` and `penable_o` are decoded from registered state only, so they are glitch-free.
- `req_i` and its payload have no effect outside IDLE. The requester holds them until `gnt_o` is asserted.
- Reset values: `psel_o`, `penable_o`, `pwrite_o`, `rvalid_o`, `err_o` = 0. `paddr_o`, `pwdata_o`, `rdata_o` = 0.
- Reset mid-transfer: the state returns to IDLE at the first edge where `rst_ni = 0`. `psel_o` and `penable_o` drop at that edge. The pending transfer is discarded and no `rvalid_o` is issued.

## Timing
- Grant in cycle N. SETUP in N+1. First ACCESS in N+2.
- With zero wait states, `rvalid_o` is asserted in cycle N+3.
- Each cycle of `pready_i = 0` in ACCESS adds one cycle of latency.
- `gnt_o` can be asserted in the same cycle as `rvalid_o`, since the FSM is already in IDLE. Maximum throughput is one transfer per 3 cycles.
- `rvalid_o` is high for exactly one cycle per granted transfer.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments on each ACCESS cycle with `pready_i = 0`.
  - If `pready_i` stays 0 for `TIMEOUT_CYCLES` consecutive ACCESS cycles, the FSM goes to IDLE and the transfer is aborted.
  - On abort, `psel_o` and `penable_o` drop on the next edge. The next cycle has `rvalid_o = 1`, `err_o = 1`, `rdata_o = 0`.
  - If `pready_i = 1` arrives in the limit cycle, `pready_i` wins and the transfer completes normally.
- Not defined: no counter logic. ACCESS waits indefinitely for `pready_i`.

## Test plan
- Zero-wait write: `addr = 0x1A10_0004`, `wdata = 0xDEAD_BEEF`, `pready_i = 1`.
  - Required: `gnt_o` in N; `psel_o = 1`, `penable_o = 0` in N+1; `penable_o = 1` in N+2.
  - Required: `rvalid_o = 1`, `err_o = 0` in N+3; APB address/data match the request.
- Read with 2 wait states: `pready_i` low for 2 ACCESS cycles, `prdata_i = 0x1234_5678`.
  - Required: `rvalid_o` in N+5 with `rdata_o = 0x1234_5678`.
- Slave error: read with `pslverr_i = 1` in the `pready_i` cycle.
  - Required: `err_o = 1`, `rvalid_o` pulses once.
- Back-to-back: `req_i` held high for 3 transfers with zero wait states.
  - Required: grants in N, N+3, N+6; exactly 3 `rvalid_o` pulses; `paddr_o` is stable throughout each SETUP/ACCESS.
- Timeout (macro on, `TIMEOUT_CYCLES = 4`): `pready_i` held 0.
  - Required: ACCESS in N+2 through N+5; `psel_o = 0` in N+6; `rvalid_o = 1`, `err_o = 1`, `rdata_o = 0` in N+6.
- Reset in ACCESS: drive `rst_ni = 0` for one cycle during ACCESS.
  - Required: `psel_o = 0` and `penable_o = 0` after that edge; no `rvalid_o`; the next request behaves as the zero-wait case.
